// File: rtl/vga_timing_gen_if.sv
// Raster output bundle from the timing generator to the pixel/colour stage and DAC pins.
// Free-running stream: one sample per pixel clock, no valid/ready back-pressure; de marks visible pixels.
interface vga_timing_gen_if;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       line_start;
    logic       frame_start;

    modport master (
        output hsync, vsync, de, x, y, line_start, frame_start
    );

    modport slave (
        input hsync, vsync, de, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator: free-running h/v counters gated by a synchronized PLL lock,
// with every output registered one clock after the counter value it decodes.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    vga_timing_gen_if.master vid
);

    localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOT - 1);
    // 11-bit bounds so a sync pulse ending exactly at 1024 still compares correctly.
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_S = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_E = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_S = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_E = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic        SYNC_ON  = (SYNC_POL != 0);

    logic       sync1;
    logic       lock_s;
    logic       en;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;

    logic       d_de;
    logic       d_hs_act;
    logic       d_vs_act;

    logic       hsync_q;
    logic       vsync_q;
    logic       de_q;
    logic [9:0] x_q;
    logic [9:0] y_q;
    logic       line_start_q;
    logic       frame_start_q;

    // The synchronizer keeps tracking lock while rst is held, so a locked PLL starts the raster
    // on the first edge after rst falls; en still forces everything idle during rst.
    always_ff @(posedge clk) begin
        sync1  <= pll_locked;
        lock_s <= sync1;
    end

    assign en = lock_s & ~rst;

    always_ff @(posedge clk) begin
        if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    always_comb begin
        d_de     = ({1'b0, h_cnt} < H_VIS) && ({1'b0, v_cnt} < V_VIS);
        d_hs_act = ({1'b0, h_cnt} >= H_SYNC_S) && ({1'b0, h_cnt} < H_SYNC_E);
        d_vs_act = ({1'b0, v_cnt} >= V_SYNC_S) && ({1'b0, v_cnt} < V_SYNC_E);
    end

    always_ff @(posedge clk) begin
        if (!en) begin
            hsync_q       <= ~SYNC_ON;
            vsync_q       <= ~SYNC_ON;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= d_hs_act ? SYNC_ON : ~SYNC_ON;
            vsync_q       <= d_vs_act ? SYNC_ON : ~SYNC_ON;
            de_q          <= d_de;
            x_q           <= d_de ? h_cnt : 10'd0;
            y_q           <= d_de ? v_cnt : 10'd0;
            line_start_q  <= (h_cnt == 10'd0);
            frame_start_q <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
        end
    end

    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.de          = de_q;
    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default timing, a shrunk raster for whole-frame behaviour,
// and the shrunk raster again with SYNC_POL=1.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic pll_locked;

    always #5 clk = ~clk;

    vga_timing_gen_if vid_d ();
    vga_timing_gen_if vid_s ();
    vga_timing_gen_if vid_p ();

    vga_timing_gen dut_d (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .vid        (vid_d)
    );

    // Small raster: H_TOT = 25 (hsync h=18..21), V_TOT = 19 (vsync v=14..15), frame = 475 clks.
    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut_s (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .vid        (vid_s)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .SYNC_POL(1)
    ) dut_p (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .vid        (vid_p)
    );

    typedef struct {
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
    } out_t;

    typedef struct {
        int   sel;
        int   off;
        out_t e;
    } vec_t;

    int tests = 0;
    int fails = 0;
    vec_t tab[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic out_t get(input int sel);
        out_t o;
        case (sel)
            0: begin
                o.hs = vid_d.hsync; o.vs = vid_d.vsync; o.de = vid_d.de;
                o.x = vid_d.x; o.y = vid_d.y; o.ls = vid_d.line_start; o.fs = vid_d.frame_start;
            end
            1: begin
                o.hs = vid_s.hsync; o.vs = vid_s.vsync; o.de = vid_s.de;
                o.x = vid_s.x; o.y = vid_s.y; o.ls = vid_s.line_start; o.fs = vid_s.frame_start;
            end
            default: begin
                o.hs = vid_p.hsync; o.vs = vid_p.vsync; o.de = vid_p.de;
                o.x = vid_p.x; o.y = vid_p.y; o.ls = vid_p.line_start; o.fs = vid_p.frame_start;
            end
        endcase
        return o;
    endfunction

    function automatic out_t mk_out(input logic hs, input logic vs, input logic de,
                                    input int x, input int y, input logic ls, input logic fs);
        out_t o;
        o.hs = hs; o.vs = vs; o.de = de;
        o.x = 10'(x); o.y = 10'(y); o.ls = ls; o.fs = fs;
        return o;
    endfunction

    function automatic vec_t mk(input int sel, input int off, input logic hs, input logic vs,
                                input logic de, input int x, input int y, input logic ls, input logic fs);
        vec_t v;
        v.sel = sel;
        v.off = off;
        v.e   = mk_out(hs, vs, de, x, y, ls, fs);
        return v;
    endfunction

    task automatic check_out(input string tag, input int sel, input out_t e);
        out_t a;
        a = get(sel);
        check({tag, ".hsync"},       32'(a.hs), 32'(e.hs));
        check({tag, ".vsync"},       32'(a.vs), 32'(e.vs));
        check({tag, ".de"},          32'(a.de), 32'(e.de));
        check({tag, ".x"},           32'(a.x),  32'(e.x));
        check({tag, ".y"},           32'(a.y),  32'(e.y));
        check({tag, ".line_start"},  32'(a.ls), 32'(e.ls));
        check({tag, ".frame_start"}, 32'(a.fs), 32'(e.fs));
    endtask

    // Polarity-inverted twin of an expected record for the SYNC_POL=1 instance.
    function automatic out_t inv_sync(input out_t e);
        out_t o;
        o = e;
        o.hs = ~e.hs;
        o.vs = ~e.vs;
        return o;
    endfunction

    task automatic check_idle(input string tag);
        out_t idle;
        idle = mk_out(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        check_out({tag, "_d"}, 0, idle);
        check_out({tag, "_s"}, 1, idle);
        check_out({tag, "_p"}, 2, inv_sync(idle));
    endtask

    task automatic check_start(input string tag);
        out_t st;
        st = mk_out(1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1);
        check_out({tag, "_d"}, 0, st);
        check_out({tag, "_s"}, 1, st);
        check_out({tag, "_p"}, 2, inv_sync(st));
    endtask

    // Counts negedges until frame_start is seen on the chosen instance, bounded by max.
    task automatic wait_fs(input string tag, input int sel, input int max, output int n);
        out_t a;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            a = get(sel);
            if (a.fs === 1'b1 || n >= max) break;
        end
        if (a.fs !== 1'b1) check({tag, ".timeout"}, 32'(0), 32'(1));
    endtask

    initial begin
        #200us;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int n;
        int de_cnt, hs_cnt, vs_cnt, bad_blank, hs_cnt_p, vs_cnt_p;
        out_t a, ap;

        // Offsets are clocks after the first frame_start; small raster: h = off%25, v = off/25.
        tab.push_back(mk(0,    0, 1, 1, 1,   0, 0, 1, 1));
        tab.push_back(mk(1,    0, 1, 1, 1,   0, 0, 1, 1));
        tab.push_back(mk(0,    1, 1, 1, 1,   1, 0, 0, 0));
        tab.push_back(mk(1,   15, 1, 1, 1,  15, 0, 0, 0));
        tab.push_back(mk(1,   16, 1, 1, 0,   0, 0, 0, 0));
        tab.push_back(mk(1,   17, 1, 1, 0,   0, 0, 0, 0));
        tab.push_back(mk(1,   18, 0, 1, 0,   0, 0, 0, 0));
        tab.push_back(mk(1,   21, 0, 1, 0,   0, 0, 0, 0));
        tab.push_back(mk(1,   22, 1, 1, 0,   0, 0, 0, 0));
        tab.push_back(mk(1,   25, 1, 1, 1,   0, 1, 1, 0));
        tab.push_back(mk(1,  290, 1, 1, 1,  15, 11, 0, 0));
        tab.push_back(mk(1,  300, 1, 1, 0,   0, 0, 1, 0));
        tab.push_back(mk(1,  349, 1, 1, 0,   0, 0, 0, 0));
        tab.push_back(mk(1,  350, 1, 0, 0,   0, 0, 1, 0));
        tab.push_back(mk(1,  399, 1, 0, 0,   0, 0, 0, 0));
        tab.push_back(mk(1,  400, 1, 1, 0,   0, 0, 1, 0));
        tab.push_back(mk(1,  474, 1, 1, 0,   0, 0, 0, 0));
        tab.push_back(mk(1,  475, 1, 1, 1,   0, 0, 1, 1));
        tab.push_back(mk(0,  639, 1, 1, 1, 639, 0, 0, 0));
        tab.push_back(mk(0,  640, 1, 1, 0,   0, 0, 0, 0));
        tab.push_back(mk(0,  655, 1, 1, 0,   0, 0, 0, 0));
        tab.push_back(mk(0,  656, 0, 1, 0,   0, 0, 0, 0));
        tab.push_back(mk(0,  751, 0, 1, 0,   0, 0, 0, 0));
        tab.push_back(mk(0,  752, 1, 1, 0,   0, 0, 0, 0));
        tab.push_back(mk(0,  799, 1, 1, 0,   0, 0, 0, 0));
        tab.push_back(mk(0,  800, 1, 1, 1,   0, 1, 1, 0));
        tab.push_back(mk(0, 1300, 1, 1, 1, 500, 1, 0, 0));
        tab.push_back(mk(0, 1599, 1, 1, 0,   0, 0, 0, 0));
        tab.push_back(mk(0, 1600, 1, 1, 1,   0, 2, 1, 0));

        // Reset held with the PLL already locked: rst dominates.
        rst        = 1'b1;
        pll_locked = 1'b1;
        repeat (5) @(negedge clk);
        check_idle("reset");

        // First frame_start on the first edge after rst falls.
        rst = 1'b0;
        @(negedge clk);
        check_start("rst_release");

        cyc = 0;
        for (int i = 0; i < tab.size(); i++) begin
            repeat (tab[i].off - cyc) @(negedge clk);
            cyc = tab[i].off;
            check_out($sformatf("tab%0d_o%0d_s%0d", i, tab[i].off, tab[i].sel), tab[i].sel, tab[i].e);
            if (tab[i].sel == 1)
                check_out($sformatf("tab%0d_o%0d_pol", i, tab[i].off), 2, inv_sync(tab[i].e));
        end

        // Align to the small raster's next frame: 1600 -> 1900 is 300 clocks.
        wait_fs("align", 1, 600, n);
        check("align_period", 32'(n), 32'(300));

        // Whole small frame sweep.
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; bad_blank = 0; hs_cnt_p = 0; vs_cnt_p = 0;
        for (int i = 0; i < 475; i++) begin
            a  = get(1);
            ap = get(2);
            if (a.de === 1'b1) de_cnt++;
            if (a.de !== 1'b1 && (a.x !== 10'd0 || a.y !== 10'd0)) bad_blank++;
            if (a.hs === 1'b0) hs_cnt++;
            if (a.vs === 1'b0) vs_cnt++;
            if (ap.hs === 1'b1) hs_cnt_p++;
            if (ap.vs === 1'b1) vs_cnt_p++;
            @(negedge clk);
        end
        check("sweep_de_count",     32'(de_cnt),    32'(192));
        check("sweep_hsync_count",  32'(hs_cnt),    32'(76));
        check("sweep_vsync_count",  32'(vs_cnt),    32'(50));
        check("sweep_blank_xy",     32'(bad_blank), 32'(0));
        check("sweep_pol_hsync",    32'(hs_cnt_p),  32'(76));
        check("sweep_pol_vsync",    32'(vs_cnt_p),  32'(50));
        a = get(1);
        check("sweep_next_frame_start", 32'(a.fs), 32'(1));

        // Lose lock at small-raster pixel (10,5), stay unlocked for 10 clocks.
        repeat (135) @(negedge clk);
        a = get(1);
        check("loss_at_x", 32'(a.x),  32'(10));
        check("loss_at_y", 32'(a.y),  32'(5));
        check("loss_at_de", 32'(a.de), 32'(1));
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("loss_idle");
        repeat (7) @(negedge clk);
        check_idle("loss_held");

        // Relock: idle for two edges, frame_start on the third.
        pll_locked = 1'b1;
        @(negedge clk);
        check_idle("relock_k");
        @(negedge clk);
        check_idle("relock_k1");
        @(negedge clk);
        check_start("relock_k2");

        repeat (25) @(negedge clk);
        check_out("relock_line1_s", 1, mk_out(1'b1, 1'b1, 1'b1, 0, 1, 1'b1, 1'b0));
        wait_fs("relock_period", 1, 600, n);
        check("relock_frame_period", 32'(n), 32'(450));
        repeat (325) @(negedge clk);
        check_out("relock_line1_d", 0, mk_out(1'b1, 1'b1, 1'b1, 0, 1, 1'b1, 1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
